// File: rtl/m68k_irq_ctrl.sv
// m68k_irq_ctrl: interrupt and watchdog controller for the main 68000.
// Latches the vblank and microcontroller interrupt requests and drives a
// priority-encoded IPL. Answers IACK cycles with an autovector request. A
// vblank-counted watchdog pulses a system reset when software stops
// touching the watchdog select.
module m68k_irq_ctrl #(
    parameter int unsigned VBL_LEVEL   = 1,
    parameter int unsigned MCU_LEVEL   = 2,
    parameter int unsigned WDOG_FRAMES = 8,
    parameter int unsigned WDOG_PULSE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vbl,
    input  logic       mcu_irq,
    input  logic       vbl_int_clr_cs,
    input  logic       cpu_int_clr_cs,
    input  logic       watchdog_clr_cs,
    input  logic       wdog_en,
    input  logic [2:0] m68k_fc,
    input  logic       m68k_as_n,
    input  logic [2:0] m68k_a,
    output logic [2:0] m68k_ipl_n,
    output logic       m68k_vpa_n,
    output logic       watchdog_reset,
    output logic       vbl_pending,
    output logic       mcu_pending
);

    localparam logic [2:0] VBL_LVL   = 3'(VBL_LEVEL);
    localparam logic [2:0] MCU_LVL   = 3'(MCU_LEVEL);
    localparam logic [7:0] FIRE_CNT  = 8'(WDOG_FRAMES - 1);
    localparam logic [7:0] PULSE_LEN = 8'(WDOG_PULSE);

    // Edge-detect history; reset to 0 so an input already high at reset
    // release counts as an event on the first cycle.
    logic vbl_q, vbl_clr_q, cpu_clr_q, wdog_clr_q;

    logic vbl_pending_q, mcu_pending_q;
    logic [2:0] ipl_n_q;
    logic       vpa_n_q;
    logic [7:0] wdog_cnt_q, wdog_cnt_d;
    logic [7:0] pulse_q, pulse_d;
    logic [2:0] level;

    logic vbl_rise, vbl_clr_rise, cpu_clr_rise, wdog_clr_rise, iack;

    assign vbl_rise      = vbl & ~vbl_q;
    assign vbl_clr_rise  = vbl_int_clr_cs & ~vbl_clr_q;
    assign cpu_clr_rise  = cpu_int_clr_cs & ~cpu_clr_q;
    assign wdog_clr_rise = watchdog_clr_cs & ~wdog_clr_q;
    assign iack          = (m68k_fc == 3'b111) && !m68k_as_n;

    // Capture previous values of the edge-detected inputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering between flops never matters.
        if (reset) begin
            vbl_q      <= 1'b0;
            vbl_clr_q  <= 1'b0;
            cpu_clr_q  <= 1'b0;
            wdog_clr_q <= 1'b0;
        end else begin
            vbl_q      <= vbl;
            vbl_clr_q  <= vbl_int_clr_cs;
            cpu_clr_q  <= cpu_int_clr_cs;
            wdog_clr_q <= watchdog_clr_cs;
        end
    end

    // Pending request flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            vbl_pending_q <= 1'b0;
            mcu_pending_q <= 1'b0;
        end else begin
            if (vbl_rise)          vbl_pending_q <= 1'b1;
            else if (vbl_clr_rise) vbl_pending_q <= 1'b0;
            if (mcu_irq)           mcu_pending_q <= 1'b1;
            else if (cpu_clr_rise) mcu_pending_q <= 1'b0;
        end
    end

    // Highest pending level wins the IPL encode.
    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational;
        // without it a missed branch would infer a latch.
        level = 3'd0;
        if (vbl_pending_q) level = VBL_LVL;
        if (mcu_pending_q && (MCU_LVL > level)) level = MCU_LVL;
    end

    // Registered CPU-facing outputs: IPL and autovector request.
    always_ff @(posedge clk) begin
        if (reset) begin
            ipl_n_q <= 3'b111;
            vpa_n_q <= 1'b1;
        end else begin
            ipl_n_q <= ~level;
            vpa_n_q <= ~(iack && ((m68k_a == VBL_LVL) || (m68k_a == MCU_LVL)));
        end
    end

    // Watchdog next state: clear beats a vblank edge, counting pauses while
    // the reset pulse runs, and reaching the frame limit launches the pulse.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        pulse_d    = pulse_q;
        if (pulse_q != 8'd0) pulse_d = pulse_q - 8'd1;
        if (!wdog_en || wdog_clr_rise || (pulse_q != 8'd0)) begin
            wdog_cnt_d = 8'd0;
        end else if (vbl_rise) begin
            if (wdog_cnt_q == FIRE_CNT) begin
                wdog_cnt_d = 8'd0;
                pulse_d    = PULSE_LEN;
            end else begin
                wdog_cnt_d = wdog_cnt_q + 8'd1;
            end
        end
    end

    // Watchdog frame counter and reset-pulse counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt_q <= 8'd0;
            pulse_q    <= 8'd0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    assign m68k_ipl_n     = ipl_n_q;
    assign m68k_vpa_n     = vpa_n_q;
    assign watchdog_reset = (pulse_q != 8'd0);
    assign vbl_pending    = vbl_pending_q;
    assign mcu_pending    = mcu_pending_q;

endmodule
